// File: rtl/route_sequencer_if.sv
// ---------------------------------------------------------------------------
// route_sequencer_if
// Groups the program-load, control and motor-controller handshake signals of
// route_sequencer so they travel as one bundle.
//   load_en / load_addr / load_cmd : program write port
//   start / abort                  : run control
//   Taskdone                       : level acknowledge from the motor controller
//   RouteRequest / PWMGo           : command and one-cycle strobe to the controller
//   busy / seq_done / fault / step : status
// Modports: slave = sequencer side, master = host / controller side.
// ---------------------------------------------------------------------------
interface route_sequencer_if;
  logic       load_en;
  logic [3:0] load_addr;
  logic [2:0] load_cmd;
  logic       start;
  logic       abort;
  logic       Taskdone;
  logic [2:0] RouteRequest;
  logic       PWMGo;
  logic       busy;
  logic       seq_done;
  logic       fault;
  logic [3:0] step;

  modport slave (
    input  load_en, load_addr, load_cmd, start, abort, Taskdone,
    output RouteRequest, PWMGo, busy, seq_done, fault, step
  );

  modport master (
    output load_en, load_addr, load_cmd, start, abort, Taskdone,
    input  RouteRequest, PWMGo, busy, seq_done, fault, step
  );
endinterface

// File: rtl/route_sequencer.sv
// ---------------------------------------------------------------------------
// route_sequencer
// Steps through a small program of route codes, presenting each one to a
// motor controller with a one-cycle PWMGo strobe and waiting for a fresh
// low-then-high Taskdone acknowledge before moving on. A per-command timer
// turns a missing acknowledge into FAULT; abort sends STOP and returns to IDLE.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   io_bus : route_sequencer_if.slave (program load, control, handshake, status)
// ---------------------------------------------------------------------------
module route_sequencer #(
  parameter int          DEPTH          = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  route_sequencer_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_NEXT, S_DONE, S_FAULT
  } state_t;

  localparam logic [2:0]  CMD_STOP       = 3'b000;
  localparam logic [2:0]  CMD_CLAW_OPEN  = 3'b110;
  localparam logic [2:0]  CMD_CLAW_CLOSE = 3'b111;
  localparam logic [3:0]  LAST_STEP      = 4'(DEPTH - 1);
  localparam logic [31:0] TIMER_LIMIT    = TIMEOUT_CYCLES - 32'd1;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_step, w_step_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  logic [2:0]  r_route, w_route_nxt;
  logic        r_pwm, w_pwm_nxt;
  logic [2:0]  r_prog [DEPTH];

  logic        w_busy;
  logic [2:0]  w_cmd;
  logic        w_immediate;
  logic        w_timed_out;
  logic [31:0] w_timer_inc;

  assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT_LOW) ||
                  (r_state == S_WAIT_HIGH) || (r_state == S_NEXT);

  // Commands the controller finishes at once; their ack may skip the low phase.
  assign w_immediate = (r_route == CMD_STOP) || (r_route == CMD_CLAW_OPEN) ||
                       (r_route == CMD_CLAW_CLOSE);
  assign w_timed_out = (r_timer >= TIMER_LIMIT);
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 32'd1;

  // Program read by compare loop so an out-of-range step reads STOP.
  always_comb begin
    w_cmd = CMD_STOP;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_step == 4'(i)) w_cmd = r_prog[i];
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_timer_nxt = r_timer;
    w_route_nxt = r_route;
    w_pwm_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (io_bus.abort) begin
          if (io_bus.start) w_state_nxt = S_IDLE;
        end else if (io_bus.start) begin
          w_step_nxt  = '0;
          w_timer_nxt = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_route_nxt = w_cmd;
        w_pwm_nxt   = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        w_timer_nxt = w_timer_inc;
        if (!io_bus.Taskdone) begin
          w_state_nxt = S_WAIT_HIGH;
        end else if (w_immediate && (r_timer != '0)) begin
          // Taskdone still high one cycle after the strobe: a 2-cycle hold,
          // so a level present only before the strobe is never accepted.
          w_state_nxt = S_NEXT;
        end else if (w_timed_out) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_WAIT_HIGH: begin
        w_timer_nxt = w_timer_inc;
        if (io_bus.Taskdone)  w_state_nxt = S_NEXT;
        else if (w_timed_out) w_state_nxt = S_FAULT;
      end
      S_NEXT: begin
        if ((r_route == CMD_STOP) || (r_step == LAST_STEP)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_step_nxt  = r_step + 4'd1;
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort outranks acknowledge and timeout decided above.
    if (w_busy && io_bus.abort) begin
      w_route_nxt = CMD_STOP;
      w_pwm_nxt   = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_timer <= '0;
      r_route <= CMD_STOP;
      r_pwm   <= 1'b0;
      // NOTE: the program is a register file, not RAM, so it can be and is
      // reset; a block RAM could not be cleared this way.
      for (int i = 0; i < DEPTH; i++) r_prog[i] <= CMD_STOP;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_timer <= w_timer_nxt;
      r_route <= w_route_nxt;
      r_pwm   <= w_pwm_nxt;
      if (io_bus.load_en && !w_busy) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (io_bus.load_addr == 4'(i)) r_prog[i] <= io_bus.load_cmd;
        end
      end
    end
  end

  assign io_bus.RouteRequest = r_route;
  assign io_bus.PWMGo        = r_pwm;
  assign io_bus.busy         = w_busy;
  assign io_bus.seq_done     = (r_state == S_DONE);
  assign io_bus.fault        = (r_state == S_FAULT);
  assign io_bus.step         = r_step;

endmodule

// File: tb/tb_route_sequencer.sv
// ---------------------------------------------------------------------------
// tb_route_sequencer
// Self-checking bench for route_sequencer (DEPTH=16, TIMEOUT_CYCLES=100).
// Expected RouteRequest values are queued as each program is started; a
// negedge monitor pops one per PWMGo strobe. Scenario tasks check status,
// latency and step inline.
// ---------------------------------------------------------------------------
module tb_route_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  route_sequencer_if bus ();

  route_sequencer #(.DEPTH(16), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_q [$];
  logic [2:0] exp_route;

  // Scoreboard: every strobe must match the next queued command.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.PWMGo === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: RouteRequest=%0d with nothing queued", bus.RouteRequest);
      end else begin
        exp_route = exp_q.pop_front();
        if (bus.RouteRequest !== exp_route) begin
          errors++;
          $display("FAIL strobe_route: got %0d expected %0d", bus.RouteRequest, exp_route);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_entry(input logic [3:0] addr, input logic [2:0] cmd);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_cmd  = cmd;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns the number of negedges waited; expiry is a failed comparison.
  task automatic wait_strobe(input string name, input int max_cyc, output int n);
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < max_cyc) begin
      @(negedge clk);
      n++;
      got = (bus.PWMGo === 1'b1);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no PWMGo within %0d cycles", name, max_cyc);
    end
  endtask

  // sel 0 waits for seq_done, sel 1 for fault.
  task automatic wait_flag(input string name, input int sel, input int max_cyc, output int n);
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < max_cyc) begin
      @(negedge clk);
      n++;
      got = (sel == 0) ? (bus.seq_done === 1'b1) : (bus.fault === 1'b1);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: flag not seen within %0d cycles", name, max_cyc);
    end
  endtask

  // Controller ack: Taskdone drops 1 cycle after the strobe, rises 10 later.
  task automatic ack_pattern();
    tick();
    bus.Taskdone = 1'b0;
    repeat (10) tick();
    bus.Taskdone = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus.RouteRequest, bus.PWMGo, bus.busy, bus.seq_done, bus.fault, bus.step} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got route=%0d pwm=%0d busy=%0d done=%0d fault=%0d step=%0d expected all 0",
               bus.RouteRequest, bus.PWMGo, bus.busy, bus.seq_done, bus.fault, bus.step);
    end
    tick();
  endtask

  task automatic test_program();
    logic [2:0] prog [4] = '{3'b001, 3'b011, 3'b110, 3'b000};
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_entry(4'(i), prog[i]);
      exp_q.push_back(prog[i]);
    end
    bus.Taskdone = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_strobe("prog_strobe", 30, n);
      checks++;
      if (n !== ((i == 0) ? 2 : 4)) begin
        errors++;
        $display("FAIL prog_latency: entry %0d got %0d cycles expected %0d", i, n, (i == 0) ? 2 : 4);
      end
      checks++;
      if (bus.step !== 4'(i)) begin
        errors++;
        $display("FAIL prog_step: got %0d expected %0d", bus.step, i);
      end
      ack_pattern();
    end
    wait_flag("prog_done", 0, 10, n);
    checks++;
    if (n !== 3 || bus.step !== 4'd3 || bus.busy !== 1'b0 || bus.RouteRequest !== 3'b000) begin
      errors++;
      $display("FAIL prog_final: got done_lat=%0d step=%0d busy=%0d route=%0d expected 3/3/0/0",
               n, bus.step, bus.busy, bus.RouteRequest);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL prog_count: got %0d strobes missing expected 0", exp_q.size());
    end
  endtask

  task automatic test_immediate();
    int n;
    do_reset();
    load_entry(4'd0, 3'b110);
    load_entry(4'd1, 3'b111);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b000);
    bus.Taskdone = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_strobe("imm_strobe", 20, n);
      checks++;
      if (n !== ((i == 0) ? 2 : 4)) begin
        errors++;
        $display("FAIL imm_latency: entry %0d got %0d cycles expected %0d", i, n, (i == 0) ? 2 : 4);
      end
    end
    wait_flag("imm_done", 0, 10, n);
    checks++;
    if (n !== 3 || bus.step !== 4'd2) begin
      errors++;
      $display("FAIL imm_final: got done_lat=%0d step=%0d expected 3/2", n, bus.step);
    end
    // start together with abort outside a run resolves as abort.
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.seq_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start: got done=%0d busy=%0d expected 0/0", bus.seq_done, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    load_entry(4'd0, 3'b001);
    exp_q.push_back(3'b001);
    bus.Taskdone = 1'b1;
    pulse_start();
    wait_strobe("to_strobe", 20, n);
    wait_flag("to_fault", 1, 200, n);
    checks++;
    if (n !== 100) begin
      errors++;
      $display("FAIL to_latency: got %0d cycles expected 100", n);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.fault !== 1'b1 || bus.step !== 4'd0 || bus.busy !== 1'b0 || bus.RouteRequest !== 3'b001) begin
      errors++;
      $display("FAIL to_hold: got fault=%0d step=%0d busy=%0d route=%0d expected 1/0/0/1",
               bus.fault, bus.step, bus.busy, bus.RouteRequest);
    end
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_entry(4'(i), 3'b001);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(3'b001);
    bus.Taskdone = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_strobe("abort_strobe", 30, n);
      if (i < 2) ack_pattern();
    end
    tick();
    bus.Taskdone = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.step !== 4'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got step=%0d busy=%0d expected 2/1", bus.step, bus.busy);
    end
    exp_q.push_back(3'b000);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.PWMGo !== 1'b1 || bus.RouteRequest !== 3'b000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: got pwm=%0d route=%0d busy=%0d expected 1/0/0",
               bus.PWMGo, bus.RouteRequest, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.PWMGo !== 1'b0 || bus.busy !== 1'b0 || bus.seq_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got pwm=%0d busy=%0d done=%0d expected 0/0/0",
               bus.PWMGo, bus.busy, bus.seq_done);
    end
    bus.Taskdone = 1'b1;
    repeat (15) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_count: got %0d strobes missing expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_entry(4'(i), 3'b001);
      exp_q.push_back(3'b001);
    end
    bus.Taskdone = 1'b1;
    pulse_start();
    wait_strobe("rmid_strobe", 20, n);
    ack_pattern();
    wait_strobe("rmid_strobe", 20, n);
    checks++;
    if (bus.step !== 4'd1) begin
      errors++;
      $display("FAIL rmid_step: got %0d expected 1", bus.step);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({bus.RouteRequest, bus.PWMGo, bus.busy, bus.seq_done, bus.fault, bus.step} !== 11'd0) begin
      errors++;
      $display("FAIL rmid_outputs: got route=%0d pwm=%0d busy=%0d done=%0d fault=%0d step=%0d expected all 0",
               bus.RouteRequest, bus.PWMGo, bus.busy, bus.seq_done, bus.fault, bus.step);
    end
    tick();
    exp_q.push_back(3'b000);
    pulse_start();
    wait_strobe("rmid_stop", 20, n);
    wait_flag("rmid_done", 0, 10, n);
    checks++;
    if (n !== 3 || bus.step !== 4'd0) begin
      errors++;
      $display("FAIL rmid_final: got done_lat=%0d step=%0d expected 3/0", n, bus.step);
    end
  endtask

  task automatic test_full();
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      load_entry(4'(i), 3'b001);
      exp_q.push_back(3'b001);
    end
    bus.Taskdone = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      wait_strobe("full_strobe", 30, n);
      checks++;
      if (bus.step !== 4'(i)) begin
        errors++;
        $display("FAIL full_step: got %0d expected %0d", bus.step, i);
      end
      if (i == 3 || i == 8) begin
        // Writing STOP while busy must be ignored or the run ends early.
        bus.load_en   = 1'b1;
        bus.load_addr = (i == 3) ? 4'd5 : 4'd15;
        bus.load_cmd  = 3'b000;
      end
      ack_pattern();
      bus.load_en = 1'b0;
    end
    wait_flag("full_done", 0, 10, n);
    checks++;
    if (bus.step !== 4'd15 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_final: got step=%0d busy=%0d expected 15/0", bus.step, bus.busy);
    end
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0 || bus.seq_done !== 1'b1) begin
      errors++;
      $display("FAIL full_count: got missing=%0d done=%0d expected 0/1", exp_q.size(), bus.seq_done);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_cmd  = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.Taskdone  = 1'b0;
    test_reset();
    test_program();
    test_immediate();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
